cpu_control_fsm: RTL and testbench

Multi-cycle control unit for the 16-bit CPU datapath. It sequences fetch, decode and execute, and drives the select and enable lines for the register bank, the A/B operand muxes, the ALU immediate path, the flag register, the program counter and the memory port. It replaces the single-cycle combinational decoder. It adds:
- an instruction register;
- load and store sequencing;
- conditional branch and jump;
- a register file size set by parameter.

---
 rtl/cpu_control_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
//   Multi-cycle control unit for the 16-bit CPU datapath. It sequences
//   FETCH -> DECODE -> EXEC (-> LOAD_WB) and drives the select/enable lines of
//   the register bank, operand muxes, immediate path, flag register, PC and
//   memory port. The instruction register lives here.
//
// Build option:
//   CTRL_HALT_EN - when defined, instruction 16'h0000 stops the core in HALT
//                  until reset. When undefined, 16'h0000 is a NOP and HALT is
//                  unreachable (halted tied to 0).
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   mem_data         memory port A read data (valid one cycle after address)
//   flags            {N,Z,F,L,C} from the flag register
//   ir               instruction register (ALU opcode)
//   mux_a_sel        Rdest field ir[11:8]
//   mux_b_sel        Rsrc/Raddr/Rtarget field ir[3:0]
//   imm              ir[7:0] sign-extended to DATA_W
//   imm_sel          ALU operand B from imm
//   reg_en           one-hot register write enable
//   wb_sel           register write source: 0 ALU, 1 mem_data
//   flag_en          capture ALU flags
//   pc_en/pc_sel     PC update; 0 = PC+1, 1 = PC+imm
//   pc_ld            load PC from mux B value (overrides pc_sel)
//   addr_sel         memory address: 0 PC, 1 mux B value
//   mem_w_en         write mux A value to memory at mux B address
//   halted           core stopped
//   state            current FSM state (debug)
module cpu_control_fsm #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 16,
    localparam int SEL_W  = $clog2(REG_CNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic [4:0]         flags,
    output logic [15:0]        ir,
    output logic [SEL_W-1:0]   mux_a_sel,
    output logic [SEL_W-1:0]   mux_b_sel,
    output logic [DATA_W-1:0]  imm,
    output logic               imm_sel,
    output logic [REG_CNT-1:0] reg_en,
    output logic               wb_sel,
    output logic               flag_en,
    output logic               pc_en,
    output logic               pc_sel,
    output logic               pc_ld,
    output logic               addr_sel,
    output logic               mem_w_en,
    output logic               halted,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        LOAD_WB = 3'd3,
        HALT    = 3'd4
    } state_t;

    typedef struct packed {
        logic [REG_CNT-1:0] reg_en;
        logic               imm_sel;
        logic               wb_sel;
        logic               flag_en;
        logic               pc_en;
        logic               pc_sel;
        logic               pc_ld;
        logic               addr_sel;
        logic               mem_w_en;
    } ctrl_t;

    state_t             state_q, state_d;
    logic [15:0]        ir_q;
    ctrl_t              ctl;

    logic [3:0]         opcode, ext;
    logic [SEL_W-1:0]   rdest, rsrc;
    logic [REG_CNT-1:0] dest_onehot;
    logic               cond_true;
    logic               is_zero_instr;
    logic               is_load;

    // flags = {N,Z,F,L,C}
    function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] f);
        logic n, z, fl, l, c;
        {n, z, fl, l, c} = f;
        case (cc)
            4'h0: cond_met = z;
            4'h1: cond_met = !z;
            4'h2: cond_met = c;
            4'h3: cond_met = !c;
            4'h4: cond_met = l;
            4'h5: cond_met = !l;
            4'h6: cond_met = n;
            4'h7: cond_met = !n;
            4'h8: cond_met = fl;
            4'h9: cond_met = !fl;
            4'hA: cond_met = !l && !z;
            4'hB: cond_met = l || z;
            4'hC: cond_met = !n && !z;
            4'hD: cond_met = n || z;
            4'hE: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

    assign opcode        = ir_q[15:12];
    assign ext           = ir_q[7:4];
    // Narrow register files simply drop the upper field bits (aliasing).
    assign rdest         = ir_q[8 +: SEL_W];
    assign rsrc          = ir_q[0 +: SEL_W];
    assign cond_true     = cond_met(ir_q[11:8], flags);
    assign is_zero_instr = (ir_q == 16'h0000);
    assign is_load       = (opcode == 4'b0100) && (ext == 4'b0000);

    always_comb begin
        dest_onehot        = '0;
        dest_onehot[rdest] = 1'b1;
    end

    // State register; ir captures the fetched word as DECODE completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                ir_q <= mem_data[15:0];
        end
    end

    // Next state
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC: begin
`ifdef CTRL_HALT_EN
                if (is_zero_instr)
                    state_d = HALT;
                else
`endif
                if (is_load)
                    state_d = LOAD_WB;
                else
                    state_d = FETCH;
            end
            LOAD_WB: state_d = FETCH;
`ifdef CTRL_HALT_EN
            HALT:    state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Control outputs, decoded from state, ir and flags
    always_comb begin
        ctl = '0;
        case (state_q)
            EXEC: begin
                if (is_zero_instr) begin
`ifndef CTRL_HALT_EN
                    ctl.pc_en = 1'b1;
`endif
                end else begin
                    case (opcode)
                        4'b0000: begin
                            // CMP only updates flags
                            ctl.reg_en  = (ext == 4'b1011) ? '0 : dest_onehot;
                            ctl.flag_en = 1'b1;
                            ctl.pc_en   = 1'b1;
                        end
                        4'b0100: begin
                            case (ext)
                                4'b0000: ctl.addr_sel = 1'b1;   // LOAD, PC advances in LOAD_WB
                                4'b0100: begin
                                    ctl.addr_sel = 1'b1;
                                    ctl.mem_w_en = 1'b1;
                                    ctl.pc_en    = 1'b1;
                                end
                                4'b1100: begin
                                    ctl.pc_ld = cond_true;
                                    ctl.pc_en = 1'b1;
                                end
                                default: ctl.pc_en = 1'b1;
                            endcase
                        end
                        4'b1100: begin
                            ctl.pc_sel = cond_true;
                            ctl.pc_en  = 1'b1;
                        end
                        default: begin
                            // CMPI only updates flags
                            ctl.imm_sel = 1'b1;
                            ctl.reg_en  = (opcode == 4'b1011) ? '0 : dest_onehot;
                            ctl.flag_en = 1'b1;
                            ctl.pc_en   = 1'b1;
                        end
                    endcase
                end
            end
            LOAD_WB: begin
                ctl.wb_sel = 1'b1;
                ctl.reg_en = dest_onehot;
                ctl.pc_en  = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    // Every output reads as zero while reset is held, which also kills any
    // write or PC update that was in flight.
    assign ir        = reset ? '0 : ir_q;
    assign mux_a_sel = reset ? '0 : rdest;
    assign mux_b_sel = reset ? '0 : rsrc;
    assign imm       = reset ? '0 : {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign imm_sel   = !reset && ctl.imm_sel;
    assign reg_en    = reset ? '0 : ctl.reg_en;
    assign wb_sel    = !reset && ctl.wb_sel;
    assign flag_en   = !reset && ctl.flag_en;
    assign pc_en     = !reset && ctl.pc_en;
    assign pc_sel    = !reset && ctl.pc_sel;
    assign pc_ld     = !reset && ctl.pc_ld;
    assign addr_sel  = !reset && ctl.addr_sel;
    assign mem_w_en  = !reset && ctl.mem_w_en;
    assign state     = reset ? 3'd0 : state_q;
`ifdef CTRL_HALT_EN
    assign halted    = !reset && (state_q == HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm. Stimulus pushes the expected control
// word for every EXEC / LOAD_WB cycle; the monitor pops and compares on each
// such cycle. Stimulus also checks reset behaviour and per-instruction latency.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_data = '0;
    logic [4:0]  flags = '0;
    logic [15:0] ir;
    logic [3:0]  mux_a_sel, mux_b_sel;
    logic [15:0] imm;
    logic        imm_sel, wb_sel, flag_en, pc_en, pc_sel, pc_ld;
    logic        addr_sel, mem_w_en, halted;
    logic [15:0] reg_en;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .mem_data(mem_data), .flags(flags),
        .ir(ir), .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel), .imm(imm),
        .imm_sel(imm_sel), .reg_en(reg_en), .wb_sel(wb_sel), .flag_en(flag_en),
        .pc_en(pc_en), .pc_sel(pc_sel), .pc_ld(pc_ld), .addr_sel(addr_sel),
        .mem_w_en(mem_w_en), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] ir;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] imm;
        logic [15:0] reg_en;
        logic [7:0]  en;      // {imm_sel,wb_sel,flag_en,pc_en,pc_sel,pc_ld,addr_sel,mem_w_en}
        logic        halted;
    } ctl_t;

    localparam logic [7:0] IS = 8'h80, WB = 8'h40, FE = 8'h20, PE = 8'h10;
    localparam logic [7:0] PS = 8'h08, PL = 8'h04, AS = 8'h02, MW = 8'h01;

    ctl_t  exp_q[$];
    string nm_q[$];

    function automatic ctl_t mk(input logic [2:0] st, input logic [15:0] instr,
                                input logic [15:0] imm_v, input logic [15:0] re,
                                input logic [7:0] en);
        ctl_t c;
        c.st = st; c.ir = instr; c.a = instr[11:8]; c.b = instr[3:0];
        c.imm = imm_v; c.reg_en = re; c.en = en; c.halted = 1'b0;
        return c;
    endfunction

    task automatic push(input string nm, input ctl_t c);
        exp_q.push_back(c);
        nm_q.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every active control cycle against the scoreboard
    always @(negedge clk) begin
        ctl_t  act, e;
        string n;
        if (!reset && (state == 3'd2 || state == 3'd3)) begin
            act = {state, ir, mux_a_sel, mux_b_sel, imm, reg_en,
                   {imm_sel, wb_sel, flag_en, pc_en, pc_sel, pc_ld, addr_sel, mem_w_en},
                   halted};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ctl: got %h expected nothing", act);
            end else begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", n, act, e);
                end
            end
        end
    end

    // Issue one instruction from FETCH and check its cycle count back to FETCH
    task automatic run(input string nm, input logic [15:0] instr, input logic [4:0] fl,
                       input int exp_cyc);
        int n;
        mem_data = instr;
        flags    = fl;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (state != 3'd0 && n < 20);
        check({nm, "_cycles"}, n, exp_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset: outputs forced low while held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold_state", state, 0);
        check("rst_hold_enables", {reg_en, pc_en, flag_en, addr_sel, halted}, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_ir", ir, 0);
        check("rst_halted", halted, 0);

        push("add_r5_r1", mk(2, 16'h0521, 16'h0021, 16'h0020, FE|PE));
        run("add_r5_r1", 16'h0521, 5'b00000, 3);

        push("load_exec", mk(2, 16'h4302, 16'h0002, 16'h0000, AS));
        push("load_wb",   mk(3, 16'h4302, 16'h0002, 16'h0008, WB|PE));
        run("load", 16'h4302, 5'b00000, 4);

        push("beq_taken", mk(2, 16'hC0FE, 16'hFFFE, 16'h0000, PS|PE));
        run("beq_taken", 16'hC0FE, 5'b01000, 3);
        push("beq_not", mk(2, 16'hC0FE, 16'hFFFE, 16'h0000, PE));
        run("beq_not", 16'hC0FE, 5'b10111, 3);

        push("jhs_taken", mk(2, 16'h4BC4, 16'hFFC4, 16'h0000, PL|PE));
        run("jhs_taken", 16'h4BC4, 5'b01000, 3);
        push("jhs_not", mk(2, 16'h4BC4, 16'hFFC4, 16'h0000, PE));
        run("jhs_not", 16'h4BC4, 5'b10101, 3);

        push("cmpi", mk(2, 16'hB705, 16'h0005, 16'h0000, IS|FE|PE));
        run("cmpi", 16'hB705, 5'b00000, 3);
        push("stor", mk(2, 16'h4A43, 16'h0043, 16'h0000, AS|MW|PE));
        run("stor", 16'h4A43, 5'b00000, 3);
        push("cmp", mk(2, 16'h03B2, 16'hFFB2, 16'h0000, FE|PE));
        run("cmp", 16'h03B2, 5'b00000, 3);
        push("addi_r3", mk(2, 16'h5380, 16'hFF80, 16'h0008, IS|FE|PE));
        run("addi_r3", 16'h5380, 5'b00000, 3);
        push("rtype_r15", mk(2, 16'h0F12, 16'h0012, 16'h8000, FE|PE));
        run("rtype_r15", 16'h0F12, 5'b00000, 3);
        push("nop_ext", mk(2, 16'h4010, 16'h0010, 16'h0000, PE));
        run("nop_ext", 16'h4010, 5'b00000, 3);
        push("blt_taken", mk(2, 16'hCC03, 16'h0003, 16'h0000, PS|PE));
        run("blt_taken", 16'hCC03, 5'b00000, 3);
        push("b_never", mk(2, 16'hCF05, 16'h0005, 16'h0000, PE));
        run("b_never", 16'hCF05, 5'b11111, 3);

        // Reset while in LOAD_WB: write suppressed, back to FETCH
        begin
            int n;
            push("load_rst_exec", mk(2, 16'h4302, 16'h0002, 16'h0000, AS));
            mem_data = 16'h4302;
            flags    = 5'b00000;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (state != 3'd3 && n < 20);
            check("reach_load_wb", state, 3);
            reset = 1'b1;
            @(negedge clk);
            check("rst_wb_suppressed", {reg_en, pc_en, wb_sel}, 0);
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            check("rst_wb_state", state, 0);
            check("rst_wb_ir", ir, 0);
        end

        push("add_after_rst", mk(2, 16'h0521, 16'h0021, 16'h0020, FE|PE));
        run("add_after_rst", 16'h0521, 5'b00000, 3);

`ifdef CTRL_HALT_EN
        begin
            int n;
            push("halt_exec", mk(2, 16'h0000, 16'h0000, 16'h0000, 8'h00));
            mem_data = 16'h0000;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (state != 3'd4 && n < 20);
            check("halt_state", state, 4);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("halt_hold", {halted, state, reg_en, pc_en, flag_en}, {1'b1, 3'd4, 16'h0, 1'b0, 1'b0});
            end
            @(posedge clk); #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            check("halt_rst_halted", halted, 0);
            check("halt_rst_state", state, 0);
        end
`else
        push("zero_nop", mk(2, 16'h0000, 16'h0000, 16'h0000, PE));
        run("zero_nop", 16'h0000, 5'b00000, 3);
        @(negedge clk);
        check("zero_nop_halted", halted, 0);
`endif

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
